// File: rtl/or_gate_checker.sv
// Drives all four input vectors into an external 2-input OR gate and counts mismatches on Y.
// Optional first-failure capture (fail_vec/fail_valid) is enabled by defining ORCHK_FIRST_FAIL_EN.
module or_gate_checker #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       A,
    output logic       B,
    input  logic       Y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [1:0] vec_idx
`ifdef ORCHK_FIRST_FAIL_EN
    ,
    output logic [1:0] fail_vec,
    output logic       fail_valid
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        CHECK,
        FINISH
    } state_e;

    // Counter runs SETTLE_CYCLES-1 down to 0, so SETTLE lasts exactly SETTLE_CYCLES cycles.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] abVec_q, abVec_d;
    logic [3:0] settleCnt_q, settleCnt_d;
    logic [2:0] errCnt_q, errCnt_d;
    logic [1:0] vecIdx_q, vecIdx_d;
    logic       pass_q, pass_d;
    logic       mismatch;
`ifdef ORCHK_FIRST_FAIL_EN
    logic [1:0] failVec_q, failVec_d;
    logic       failValid_q, failValid_d;
`endif

    // Case inequality so an X/Z response is treated as a wrong answer.
    assign mismatch = (Y !== (abVec_q[1] | abVec_q[0]));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = APPLY;
            APPLY:   state_d = SETTLE;
            SETTLE:  if (settleCnt_q == 4'd0) state_d = CHECK;
            CHECK:   state_d = (vecIdx_q == 2'd3) ? FINISH : APPLY;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        abVec_d     = abVec_q;
        settleCnt_d = settleCnt_q;
        errCnt_d    = errCnt_q;
        vecIdx_d    = vecIdx_q;
        pass_d      = pass_q;
`ifdef ORCHK_FIRST_FAIL_EN
        failVec_d   = failVec_q;
        failValid_d = failValid_q;
`endif
        case (state_q)
            IDLE: begin
                abVec_d = 2'b00;
                if (start) begin
                    errCnt_d = 3'd0;
                    vecIdx_d = 2'd0;
                    pass_d   = 1'b0;
`ifdef ORCHK_FIRST_FAIL_EN
                    failVec_d   = 2'b00;
                    failValid_d = 1'b0;
`endif
                end
            end
            APPLY: begin
                abVec_d     = vecIdx_q;
                settleCnt_d = SETTLE_LOAD;
            end
            SETTLE: begin
                if (settleCnt_q != 4'd0) settleCnt_d = settleCnt_q - 4'd1;
            end
            CHECK: begin
                if (mismatch) begin
                    if (errCnt_q != 3'd4) errCnt_d = errCnt_q + 3'd1;
`ifdef ORCHK_FIRST_FAIL_EN
                    if (!failValid_q) begin
                        failVec_d   = abVec_q;
                        failValid_d = 1'b1;
                    end
`endif
                end
                if (vecIdx_q != 2'd3) vecIdx_d = vecIdx_q + 2'd1;
            end
            FINISH: begin
                pass_d  = (errCnt_q == 3'd0);
                abVec_d = 2'b00;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            abVec_q     <= 2'b00;
            settleCnt_q <= 4'd0;
            errCnt_q    <= 3'd0;
            vecIdx_q    <= 2'd0;
            pass_q      <= 1'b0;
`ifdef ORCHK_FIRST_FAIL_EN
            failVec_q   <= 2'b00;
            failValid_q <= 1'b0;
`endif
        end else begin
            abVec_q     <= abVec_d;
            settleCnt_q <= settleCnt_d;
            errCnt_q    <= errCnt_d;
            vecIdx_q    <= vecIdx_d;
            pass_q      <= pass_d;
`ifdef ORCHK_FIRST_FAIL_EN
            failVec_q   <= failVec_d;
            failValid_q <= failValid_d;
`endif
        end
    end

    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == FINISH);
        A       = abVec_q[1];
        B       = abVec_q[0];
        pass    = pass_q;
        err_cnt = errCnt_q;
        vec_idx = vecIdx_q;
`ifdef ORCHK_FIRST_FAIL_EN
        fail_vec   = failVec_q;
        fail_valid = failValid_q;
`endif
    end

endmodule

// File: tb/tb_or_gate_checker.sv
// Self-checking bench for or_gate_checker: the gate under test is a 4-entry truth table
// (randomised or directed) and expectations come from a vector-by-vector reference model.
module tb_or_gate_checker;

    localparam int S0    = 2;
    localparam int S1    = 1;
    localparam int DONE0 = 4 * (S0 + 2) + 1;
    localparam int DONE1 = 4 * (S1 + 2) + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start1;
    logic [3:0] yTable;

    logic       A, B, Y, busy, done, pass;
    logic [2:0] errCnt;
    logic [1:0] vecIdx;

    logic       a1, b1, y1, busy1, done1, pass1;
    logic [2:0] errCnt1;
    logic [1:0] vecIdx1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Gate under test: truth table indexed by {A,B}.
    assign Y  = yTable[{A, B}];
    assign y1 = a1 | b1;

    or_gate_checker #(.SETTLE_CYCLES(S0)) dut (
        .clk(clk), .rst(rst), .start(start),
        .A(A), .B(B), .Y(Y),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(errCnt), .vec_idx(vecIdx)
    );

    or_gate_checker #(.SETTLE_CYCLES(S1)) dutShort (
        .clk(clk), .rst(rst), .start(start1),
        .A(a1), .B(b1), .Y(y1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(errCnt1), .vec_idx(vecIdx1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Reference: count vectors where the table disagrees with a true OR, capped at 4.
    function automatic int modelErrors(input logic [3:0] tbl);
        int n;
        logic [1:0] v;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            if (tbl[i] != (v[1] | v[0])) n++;
        end
        return (n > 4) ? 4 : n;
    endfunction

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
        checkOutput({tag, "_pass"}, 32'(pass), 0);
        checkOutput({tag, "_err"}, 32'(errCnt), 0);
        checkOutput({tag, "_vec"}, 32'(vecIdx), 0);
        checkOutput({tag, "_A"}, 32'(A), 0);
        checkOutput({tag, "_B"}, 32'(B), 0);
    endtask

    task automatic waitIdle();
        bit seenIdle;
        seenIdle = 1'b0;
        for (int i = 0; i < 100 && !seenIdle; i++) begin
            @(negedge clk);
            if (!busy) seenIdle = 1'b1;
        end
        checkOutput("idleTimeout", 32'(seenIdle), 1);
    endtask

    // One full run; extraPulseAt>0 pulses start again mid-run, holdStart keeps start high.
    task automatic applyStimulus(input logic [3:0] tbl, input int extraPulseAt, input bit holdStart);
        int expErr;
        int doneCycle;
        int doneCount;
        expErr    = modelErrors(tbl);
        yTable    = tbl;
        doneCycle = -1;
        doneCount = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= DONE0 + 3; cyc++) begin
            @(negedge clk);
            if (!holdStart) start = (cyc == extraPulseAt);
            if (done) begin
                doneCount++;
                if (doneCycle < 0) doneCycle = cyc;
            end
            if (cyc <= DONE0) checkOutput($sformatf("busy@%0d", cyc), 32'(busy), 1);
            for (int k = 0; k < 4; k++) begin
                if (cyc == k * (S0 + 2) + S0 + 2) begin
                    checkOutput($sformatf("ab_vec%0d", k), 32'({A, B}), 32'(k));
                    checkOutput($sformatf("vecIdx%0d", k), 32'(vecIdx), 32'(k));
                end
            end
            if (cyc == DONE0 + 1) begin
                checkOutput("busyAfterFinish", 32'(busy), 0);
                checkOutput("pass", 32'(pass), 32'(expErr == 0));
                checkOutput("errCnt", 32'(errCnt), 32'(expErr));
                checkOutput("idleAB", 32'({A, B}), 0);
            end
            if (cyc == DONE0 + 2 && holdStart) begin
                checkOutput("heldRestartBusy", 32'(busy), 1);
                checkOutput("heldRestartPassClr", 32'(pass), 0);
                checkOutput("heldRestartErrClr", 32'(errCnt), 0);
                start = 1'b0;
            end
            if (cyc == DONE0 + 3 && !holdStart) begin
                checkOutput("passHold", 32'(pass), 32'(expErr == 0));
                checkOutput("errHold", 32'(errCnt), 32'(expErr));
            end
        end
        checkOutput("doneCount", 32'(doneCount), 1);
        checkOutput("doneCycle", 32'(doneCycle), 32'(DONE0));
        start = 1'b0;
        if (holdStart) waitIdle();
    endtask

    task automatic runResetAbort();
        int doneSeen;
        doneSeen = 0;
        yTable = 4'b0000;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 9) checkOutput("errBeforeAbort", 32'(errCnt), 1);
            if (cyc == 10) rst = 1'b1;
        end
        @(negedge clk);
        checkResetValues("abort");
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) doneSeen++;
        end
        checkOutput("noRunAfterAbort", 32'(doneSeen), 0);
    endtask

    task automatic runShort();
        int doneCycle;
        doneCycle = -1;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= DONE1 + 2; cyc++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (done1 && doneCycle < 0) doneCycle = cyc;
            if (cyc == DONE1 + 1) begin
                checkOutput("shortPass", 32'(pass1), 1);
                checkOutput("shortErr", 32'(errCnt1), 0);
            end
        end
        checkOutput("shortDoneCycle", 32'(doneCycle), 32'(DONE1));
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        yTable = 4'b1110;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;

        applyStimulus(4'b1110, 0, 1'b0);
        applyStimulus(4'b0000, 0, 1'b0);
        applyStimulus(4'b1000, 0, 1'b0);
        applyStimulus(4'b0001, 0, 1'b0);
        applyStimulus(4'b1110, 5, 1'b0);
        applyStimulus(4'b1110, 0, 1'b1);
        runResetAbort();
        applyStimulus(4'b1110, 0, 1'b0);
        runShort();

        for (int r = 0; r < 8; r++) begin
            applyStimulus(4'($urandom_range(0, 15)), int'($urandom_range(0, 17)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/or_gate_checker.md
OR_GATE_CHECKER -- requirements
Module: or_gate_checker

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 2, number of clk cycles between driving a vector and sampling Y (legal range 1..15).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to run one full 4-vector check; sampled only in IDLE.
REQ-005 Port: A  output  1  stimulus to the 2-input gate under test, registered.
REQ-006 Port: B  output  1  stimulus to the 2-input gate under test, registered.
REQ-007 Port: Y  input  1  response from the gate under test.
REQ-008 Port: busy  output  1  high in every state except IDLE.
REQ-009 Port: done  output  1  one-cycle pulse at end of a run.
REQ-010 Port: pass  output  1  result of the last completed run; 1 = zero mismatches.
REQ-011 Port: err_cnt  output  3  mismatch count of the current or last run (0..4).
REQ-012 Port: vec_idx  output  2  index of the vector being applied; {A,B} = vec_idx, A is the MSB.

Function
REQ-013 The FSM SHALL have states IDLE, APPLY, SETTLE, CHECK and FINISH.
REQ-014 IDLE: A=B=0; on start=1, go to APPLY, clear err_cnt and vec_idx to 0, and clear pass to 0.
REQ-015 APPLY (1 cycle): register {A,B} <= vec_idx, load the settle counter, and go to SETTLE.
REQ-016 SETTLE: hold A and B for exactly SETTLE_CYCLES cycles, then go to CHECK.
REQ-017 CHECK (1 cycle): compare Y with the expected value (A | B). On mismatch, err_cnt increments by 1, saturating at 4.
REQ-018 CHECK exit: if vec_idx==3, go to FINISH; otherwise increment vec_idx and go to APPLY.
REQ-019 FINISH (1 cycle): assert done=1, set pass=(err_cnt==0), and return to IDLE.
REQ-020 Vector order is fixed: 00, 01, 10, 11.
REQ-021 Latency: done SHALL be high in cycle 4*(SETTLE_CYCLES+2)+1 after the edge that samples start; this is cycle 17 for the default.
REQ-022 start asserted while busy=1 SHALL be ignored, and no restart is queued.
REQ-023 start held high continuously SHALL begin a new run on the cycle after FINISH, when the FSM is back in IDLE.
REQ-024 pass and err_cnt SHALL hold their values after FINISH until the next accepted start or reset.
REQ-025 An unknown or X value on Y SHALL count as a mismatch in simulation.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL set state=IDLE, A=0, B=0, busy=0, done=0, pass=0, err_cnt=0 and vec_idx=0.
REQ-027 rst SHALL take priority over start and over all FSM transitions.
REQ-028 rst asserted mid-run SHALL abort the run with no done pulse; the next run requires a new start.

Configuration
REQ-029 Macro ORCHK_FIRST_FAIL_EN, when defined, SHALL add output fail_vec (2 bits) and output fail_valid (1 bit).
REQ-030 With the macro defined, the first mismatch in a run SHALL latch {A,B} into fail_vec and set fail_valid=1. Later mismatches in the same run SHALL not alter either output.
REQ-031 With the macro defined, both fail_vec and fail_valid SHALL clear on reset and on an accepted start.
REQ-032 Without the macro, fail_vec and fail_valid SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-033 Y driven by a correct OR of A,B, SETTLE_CYCLES=2, one start pulse -> done at cycle 17, pass=1, err_cnt=0, A/B sequence 00,01,10,11.
REQ-034 Y tied to 0 -> err_cnt=3, pass=0. With ORCHK_FIRST_FAIL_EN defined, fail_vec=01 and fail_valid=1.
REQ-035 Y driven by A AND B -> err_cnt=2 (vectors 01 and 10 fail), pass=0.
REQ-036 start pulsed again at cycle 5 of a run -> run is unaffected, exactly one done pulse, busy stays high until FINISH.
REQ-037 rst asserted during SETTLE of vector 10 -> next cycle: all outputs at reset values, no done pulse. A new start then completes normally with done at cycle 17.
REQ-038 SETTLE_CYCLES=1 with a correct OR -> done at cycle 13, pass=1.
